// File: rtl/apb_master_nslv.sv
// Parametrised APB3 bridge from the core request bus to NUM_SLAVES equal address windows.
// Define APB_PSLVERR_EN to add a per-slave PSLVERR input that feeds err on completion.
module apb_master_nslv #(
   parameter int          NUM_SLAVES     = 8,
   parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
   parameter int          SLOT_BITS      = 12,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                       PCLK,
   input  logic                       PRESET,
   input  logic                       transfer,
   input  logic                       write,
   input  logic [31:0]                addr,
   input  logic [31:0]                wdata,
   output logic [31:0]                rdata,
   output logic                       ready,
   output logic                       err,
   output logic [31:0]                PADDR,
   output logic                       PWRITE,
   output logic                       PENABLE,
   output logic [31:0]                PWDATA,
   output logic [NUM_SLAVES-1:0]      PSEL,
   input  logic [32*NUM_SLAVES-1:0]   PRDATA,
`ifdef APB_PSLVERR_EN
   input  logic [NUM_SLAVES-1:0]      PSLVERR,
`endif
   input  logic [NUM_SLAVES-1:0]      PREADY
);

   localparam int IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TO_LAST);
   localparam logic [NUM_SLAVES-1:0] SEL_ONE  = NUM_SLAVES'(1);
   // 33-bit bounds so a window ending at 4 GB does not wrap to zero
   localparam logic [32:0] BASE33 = {1'b0, BASE_ADDR};
   localparam logic [32:0] TOP33  = BASE33 + (33'(NUM_SLAVES) << SLOT_BITS);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] cnt;

   logic             hit;
   logic [31:0]      offs;
   logic [IDX_W-1:0] idx_d;
   logic             sel_ready;
   logic             sel_err;
   logic [31:0]      sel_rdata;

   assign hit   = ({1'b0, addr} >= BASE33) && ({1'b0, addr} < TOP33);
   assign offs  = addr - BASE_ADDR;
   assign idx_d = IDX_W'(offs >> SLOT_BITS);

   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_ready = PREADY[i];
            sel_rdata = PRDATA[32*i +: 32];
`ifdef APB_PSLVERR_EN
            sel_err   = PSLVERR[i];
`endif
         end
      end
   end

   // Completion is decoded from state so a reset mid-access kills the pulse at once
   always_comb begin
      ready = 1'b0;
      err   = 1'b0;
      rdata = '0;
      case (state)
         ACCESS: begin
            if (sel_ready) begin
               ready = 1'b1;
               err   = sel_err;
               rdata = (PWRITE || sel_err) ? 32'h0 : sel_rdata;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
               ready = 1'b1;
               err   = 1'b1;
            end
         end
         ERROR: begin
            ready = 1'b1;
            err   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state   <= IDLE;
         idx_q   <= '0;
         cnt     <= '0;
         PADDR   <= '0;
         PWDATA  <= '0;
         PWRITE  <= 1'b0;
         PENABLE <= 1'b0;
         PSEL    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (transfer) begin
                  if (hit) begin
                     PADDR  <= addr;
                     PWDATA <= wdata;
                     PWRITE <= write;
                     idx_q  <= idx_d;
                     PSEL   <= SEL_ONE << idx_d;
                     state  <= SETUP;
                  end else begin
                     state  <= ERROR;
                  end
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               cnt     <= '0;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (ready) begin
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  state   <= IDLE;
               end else if (TIMEOUT_CYCLES != 0) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ERROR: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Randomised bench for apb_master_nslv: behavioural APB slaves with programmable wait
// states, and an address-map / latency model derived from the bridge's contract.
module tb_apb_master_nslv;

   localparam int          NS   = 8;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          SLOT = 12;
   localparam int          TO   = 4;

   logic                PCLK = 1'b0;
   logic                PRESET;
   logic                transfer, write;
   logic [31:0]         addr, wdata, rdata;
   logic                ready, err;
   logic [31:0]         PADDR, PWDATA;
   logic                PWRITE, PENABLE;
   logic [NS-1:0]       PSEL, PREADY;
   logic [32*NS-1:0]    PRDATA;
   logic [NS-1:0]       PSLVERR;

   logic [31:0] sdata [NS];
   logic [NS-1:0] slverr;
   int waits [NS];
   int acc_cnt [NS];

   int n_chk = 0;
   int n_fail = 0;

   always #5 PCLK = ~PCLK;

   apb_master_nslv #(
      .NUM_SLAVES(NS), .BASE_ADDR(BASE), .SLOT_BITS(SLOT), .TIMEOUT_CYCLES(TO)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
      .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
      .PSEL(PSEL), .PRDATA(PRDATA),
`ifdef APB_PSLVERR_EN
      .PSLVERR(PSLVERR),
`endif
      .PREADY(PREADY)
   );

   // Slaves: a selected slave holds PREADY low for waits[i] access cycles;
   // unselected slaves show PREADY=1 and their own data as noise.
   always_comb begin
      PRDATA = '0;
      for (int i = 0; i < NS; i++) begin
         PRDATA[32*i +: 32] = sdata[i];
         PREADY[i]  = PSEL[i] ? (acc_cnt[i] >= waits[i]) : 1'b1;
         PSLVERR[i] = slverr[i];
      end
   end

   always @(posedge PCLK) begin
      for (int i = 0; i < NS; i++) begin
         if (!PSEL[i]) acc_cnt[i] <= 0;
         else if (PENABLE && !PREADY[i]) acc_cnt[i] <= acc_cnt[i] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic rnd_slaves(input bit allow_err);
      for (int i = 0; i < NS; i++) begin
         sdata[i]  = $urandom;
         slverr[i] = allow_err && ($urandom_range(0, 3) == 0);
         waits[i]  = 0;
      end
   endtask

   // Issues one request and checks the whole handshake against the address-map model.
   task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int tw);
      longint unsigned la, lb, top;
      bit hit, to, done, exp_err;
      int idx, lat;
      logic [31:0] exp_rd, exp_sel;
      la  = a;
      lb  = BASE;
      top = lb + (longint'(NS) << SLOT);
      hit = (la >= lb) && (la < top);
      idx = hit ? int'((la - lb) >> SLOT) : 0;
      to  = hit && (tw >= TO);
      if (hit) waits[idx] = tw;
      lat = !hit ? 1 : (to ? 1 + TO : 2 + tw);
      exp_err = !hit || to;
`ifdef APB_PSLVERR_EN
      if (hit && !to) exp_err = slverr[idx];
`endif
      exp_rd = (w || exp_err) ? 32'h0 : sdata[idx];
      @(negedge PCLK);
      transfer = 1'b1; write = w; addr = a; wdata = d;
      done = 0;
      for (int k = 1; k <= 40 && !done; k++) begin
         @(negedge PCLK);
         exp_sel = (hit && k <= lat) ? (32'h1 << idx) : 32'h0;
         chk("psel", 32'(PSEL), exp_sel);
         chk("penable", 32'(PENABLE), 32'(hit && k >= 2 && k <= lat));
         if (hit) begin
            chk("paddr", PADDR, a);
            chk("pwdata", PWDATA, d);
            chk("pwrite", 32'(PWRITE), 32'(w));
         end
         if (ready) begin
            chk("latency", 32'(k), 32'(lat));
            chk("err", 32'(err), 32'(exp_err));
            chk("rdata", rdata, exp_rd);
            done = 1;
            transfer = 1'b0;
         end else begin
            // requests outside IDLE must be ignored
            transfer = 1'b1; write = $urandom; addr = $urandom; wdata = $urandom;
         end
      end
      if (!done) begin
         chk("ready_seen", 32'h0, 32'h1);
         transfer = 1'b0;
      end
      @(negedge PCLK);
      chk("idle_ready", 32'(ready), 32'h0);
      chk("idle_psel", 32'(PSEL), 32'h0);
   endtask

   initial begin
      bit bad;
      logic [31:0] a;
      int m, s;
      PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
      rnd_slaves(0);
      repeat (3) @(negedge PCLK);
      chk("rst_psel", 32'(PSEL), 32'h0);
      chk("rst_penable", 32'(PENABLE), 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_paddr", PADDR, 32'h0);
      chk("rst_pwdata", PWDATA, 32'h0);
      chk("rst_pwrite", 32'(PWRITE), 32'h0);
      PRESET = 1'b0;

      rnd_slaves(0);
      do_xfer(1'b1, 32'h1000_2004, 32'hDEAD_BEEF, 0);
      rnd_slaves(0); sdata[7] = 32'h0000_00A5;
      do_xfer(1'b0, 32'h1000_7000, 32'h0, 3);
      rnd_slaves(0);
      do_xfer(1'b0, 32'h2000_0000, 32'h0, 0);
      do_xfer(1'b0, 32'h1000_8000, 32'h0, 0);
      do_xfer(1'b0, 32'hFFFF_FFFF, 32'h0, 0);
      do_xfer(1'b0, 32'h0FFF_FFFF, 32'h0, 0);
      rnd_slaves(0);
      do_xfer(1'b0, 32'h1000_1000, 32'h0, 100);
      rnd_slaves(0);
      do_xfer(1'b0, 32'h1000_0010, 32'h0, 0);
`ifdef APB_PSLVERR_EN
      rnd_slaves(0); slverr[5] = 1'b1; sdata[5] = 32'h0000_1234;
      do_xfer(1'b0, 32'h1000_5000, 32'h0, 0);
`endif

      // reset in the middle of an access to slave 3
      rnd_slaves(0); waits[3] = 100;
      @(negedge PCLK);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_3008;
      @(negedge PCLK); transfer = 1'b0;
      @(negedge PCLK);
      chk("pre_rst_penable", 32'(PENABLE), 32'h1);
      PRESET = 1'b1;
      #1;
      chk("mid_rst_psel", 32'(PSEL), 32'h0);
      chk("mid_rst_penable", 32'(PENABLE), 32'h0);
      chk("mid_rst_ready", 32'(ready), 32'h0);
      chk("mid_rst_paddr", PADDR, 32'h0);
      @(negedge PCLK); PRESET = 1'b0;
      bad = 0;
      repeat (8) begin
         @(negedge PCLK);
         if (ready || PSEL != '0) bad = 1;
      end
      chk("post_rst_quiet", 32'(bad), 32'h0);

      for (int n = 0; n < 250; n++) begin
         rnd_slaves(1);
         m = $urandom_range(0, 11);
         s = $urandom_range(0, NS - 1);
         case (m)
            6:       a = $urandom % BASE;
            7:       a = BASE + (NS << SLOT);
            8:       a = BASE + (NS << SLOT) + $urandom_range(0, 32'h0FFF_FFFF);
            9:       a = 32'hFFFF_FFFF;
            10:      a = BASE;
            11:      a = BASE + (NS << SLOT) - 1;
            default: a = BASE + (s << SLOT) + $urandom_range(0, (1 << SLOT) - 1);
         endcase
         do_xfer(1'($urandom), a, $urandom, $urandom_range(0, 5));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master_nslv.md
Name: apb_master_nslv

Overview:
Parametrised APB3 bridge. It replaces the fixed six-slave APB master between the RV32I core bus (transfer/ready/write/addr/wdata/rdata) and the peripheral slaves.
- Slave count and address map are generic: NUM_SLAVES equal windows starting at BASE_ADDR.
- Adds unmapped-address error response and a PREADY timeout watchdog.
- Slave vectors are packed, so the MCU top instantiates one bridge for any peripheral set.

Parameters:
NUM_SLAVES, 8, number of APB slaves (1..16); PSEL/PREADY/PRDATA vector sizes.
BASE_ADDR, 32'h1000_0000, byte address of slave 0 window; aligned to 2**SLOT_BITS.
SLOT_BITS, 12, log2 window size per slave (default 4 KB).
TIMEOUT_CYCLES, 255, max ACCESS cycles waiting for PREADY; 0 disables watchdog.

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
transfer  in  1  CPU request strobe; sampled only in IDLE
write  in  1  1=write, 0=read; latched with transfer
addr  in  32  byte address; latched with transfer
wdata  in  32  write data; latched with transfer
rdata  out  32  read data; valid while ready=1
ready  out  1  one-cycle completion pulse
err  out  1  qualifies ready: unmapped, timeout or slave error
PADDR  out  32  APB address (latched addr)
PWRITE  out  1  APB direction
PENABLE  out  1  APB access phase
PWDATA  out  32  APB write data
PSEL  out  NUM_SLAVES  one-hot slave select
PRDATA  in  32*NUM_SLAVES  slave i read data at bits [32*i+31:32*i]
PREADY  in  NUM_SLAVES  slave ready, per slave

Behaviour:
- Clock and reset: single clock PCLK; PRESET is asynchronous, active-high.
- Reset values: state=IDLE. PADDR, PWDATA, PWRITE, PENABLE, PSEL, rdata, ready, err, timeout counter are all 0.
- Decode:
  - hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR + NUM_SLAVES<<SLOT_BITS).
  - idx = (addr - BASE_ADDR) >> SLOT_BITS.
  - Decode is done on the incoming addr in IDLE; idx is registered.
- FSM states: IDLE, SETUP, ACCESS, ERROR.
- IDLE:
  - transfer=1 && hit: latch addr/wdata/write into PADDR/PWDATA/PWRITE, latch idx, go to SETUP.
  - transfer=1 && !hit: go to ERROR; no PSEL asserted.
  - transfer=0: stay in IDLE.
- SETUP: PSEL[idx]=1, PENABLE=0, counter cleared, go to ACCESS unconditionally.
- ACCESS: PSEL[idx]=1, PENABLE=1.
  - PREADY[idx]=1: ready=1, err=0, rdata=PRDATA[idx] (0 on writes), go to IDLE.
  - Else counter increments.
  - TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 with PREADY low: ready=1, err=1, rdata=0, drop PSEL/PENABLE, go to IDLE.
- ERROR: one cycle; ready=1, err=1, rdata=0, then go to IDLE.
- ready, err and rdata are combinational from state and the selected slave inputs. ready is high for exactly one cycle per accepted transfer.
- Latency:
  - Zero-wait slave: transfer in cycle N, SETUP N+1, ACCESS/ready N+2.
  - Each PREADY-low cycle adds one cycle.
  - Unmapped address: ready at N+1.
- transfer asserted in any state other than IDLE is ignored; no queuing.
- Next transfer is accepted earliest the cycle after ready.
- PREADY/PRDATA of non-selected slaves are ignored. PSEL is strictly one-hot or zero.
- PADDR/PWDATA/PWRITE hold stable from SETUP through the end of ACCESS. They keep their last value in IDLE.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0; no ready pulse is issued.
- addr exactly at BASE_ADDR + NUM_SLAVES<<SLOT_BITS is unmapped. Address arithmetic is 32-bit unsigned with no wrap.

Optional Feature:
APB_PSLVERR_EN
- Defined: adds input PSLVERR [NUM_SLAVES]. In the ACCESS completion cycle, err = PSLVERR[idx], and rdata is forced to 0 when err=1.
- Undefined: the port is absent, and err is asserted only for unmapped addresses and timeouts.

Test Plan:
1. Write 0xDEADBEEF to 0x1000_2004, slave 2 PREADY tied 1 -> PSEL=0x04 for 2 cycles, PENABLE in 2nd, PWDATA=0xDEADBEEF, ready at N+2, err=0.
2. Read 0x1000_7000, slave 7 PRDATA=0x0000_00A5, PREADY low 3 ACCESS cycles -> ready at N+5, rdata=0xA5, err=0, PSEL=0x80 throughout.
3. Read 0x2000_0000 and 0x1000_8000 -> no PSEL bit set, ready+err at N+1, rdata=0.
4. TIMEOUT_CYCLES=4, slave 1 PREADY stuck 0 -> ready+err after 4 ACCESS cycles, PSEL returns to 0, next transfer to slave 0 completes normally.
5. PRESET asserted during ACCESS to slave 3 -> PSEL/PENABLE/ready 0 immediately; no ready pulse after reset release.
6. APB_PSLVERR_EN defined, slave 5 returns PSLVERR=1 with PRDATA=0x1234 -> ready=1, err=1, rdata=0.
